bcd_counter_display: RTL and testbench
======================================

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits and seven-segment displays, legal range 1..8.
REQ-002 Parameter PRESCALE, default 50000000: Clock cycles per count step, legal range 2..2^26.
REQ-003 Clock  input  1: single clock, all state on its rising edge.
REQ-004 Resetn  input  1: reset, asynchronous, active-low.
REQ-005 En  input  1: count enable; low freezes both the prescaler and the count.
REQ-006 Up  input  1: direction; 1 = increment, 0 = decrement.
REQ-007 Load  input  1: synchronous load of D.
REQ-008 D  input  4*DIGITS: load value, digit k in bits [4k+3:4k].
REQ-009 Q  output  4*DIGITS: current BCD count, digit k in bits [4k+3:4k].
REQ-010 HEX  output  7*DIGITS: segment drive, display k in bits [7k+6:7k], bit order g..a (bit 6 = g), active-low.
REQ-011 Wrap  output  1: one-cycle pulse on a roll-over step.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 while En=1 and hold while En=0; tick SHALL assert in the cycle where prescaler = PRESCALE-1 and En=1, and the prescaler SHALL return to 0 on the next edge.
REQ-013 On tick with Up=1, Q SHALL increment in BCD: digit 9 -> 0 with carry into digit k+1; all-9s -> all-0s.
REQ-014 On tick with Up=0, Q SHALL decrement in BCD: digit 0 -> 9 with borrow from digit k+1; all-0s -> all-9s.
REQ-015 Wrap SHALL be 1 for exactly the cycle after an all-9s->0 or all-0s->9s step, and 0 otherwise.
REQ-016 Load=1 SHALL override En and tick.
REQ-017 On the next edge after Load=1, Q SHALL take D, with any digit >9 replaced by 0.
REQ-018 Load=1 SHALL clear the prescaler to 0 and force Wrap to 0.
REQ-019 A change on Up SHALL affect only ticks on or after the edge where it is sampled; a pending carry SHALL never be split across directions.
REQ-020 HEX SHALL be registered: display k reflects Q digit k one Clock later.
REQ-021 Active-low codes, hex g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
REQ-022 Q digits SHALL never hold values above 9 under any input sequence.

Reset
REQ-023 Resetn=0 SHALL immediately, without a Clock edge, set the prescaler, Q and Wrap to 0 and HEX to all-"0" (40 per digit, subject to REQ-026).
REQ-024 Deassertion of Resetn SHALL be the only exit from reset; counting resumes from a prescaler value of 0.
REQ-025 Reset asserted mid-count or mid-load SHALL discard the operation with no residual Wrap pulse.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined, every display above the most significant non-zero digit SHALL show blank (7F), with display 0 always lit; all-zero Q shows "0" on display 0 only.
REQ-027 Without LEADING_ZERO_BLANK_EN, all displays SHALL always show their digit.
REQ-028 Q, Wrap and timing SHALL be identical with and without LEADING_ZERO_BLANK_EN.

Verification (DIGITS=2, PRESCALE=4)
REQ-029 Reset then En=1, Up=1 for 40 cycles -> Q steps every 4 cycles 00,01,...,10; HEX[6:0]=40 and HEX[13:7]=79 one cycle after Q=10.
REQ-030 Load D=8'h98, then En=1, Up=1 for 8 cycles -> Q 98->99->00; Wrap is 1 for one cycle after 00; HEX=40/40 without the macro, 7F/40 with it.
REQ-031 Load D=8'h00, Up=0, En=1 -> after the first tick Q=99 with a Wrap pulse; after the next tick Q=98.
REQ-032 Load D=8'hAF -> Q=00; Load asserted together with a tick -> Q=D and the prescaler restarts at 0.
REQ-033 En=0 for 20 cycles mid-count -> Q and the prescaler frozen; Resetn low for a fraction of a cycle -> Q=00 and Wrap=0 before the next edge.

Source files
------------

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: prescaled up/down BCD counter with registered
// seven-segment outputs (active-low, bit order g..a).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks displays above the
// most significant non-zero digit (display 0 always lit).
module bcd_counter_display #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50000000
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  Wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]       presc;
    logic                tick;
    logic [4*DIGITS:0]   step_result;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Full-display encode; blanking walks from the top digit downward.
    function automatic logic [7*DIGITS-1:0] encode_all(input logic [4*DIGITS-1:0] qv);
        logic [7*DIGITS-1:0] segs;
`ifdef LEADING_ZERO_BLANK_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        segs = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            segs[7*k +: 7] = seg7(qv[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && upper_zero && qv[4*k +: 4] == 4'd0)
                segs[7*k +: 7] = 7'h7F;
            if (qv[4*k +: 4] != 4'd0)
                upper_zero = 1'b0;
`endif
        end
        return segs;
    endfunction

    // Loaded digits above 9 become 0 so Q never leaves the BCD range.
    function automatic logic [4*DIGITS-1:0] load_clean(input logic [4*DIGITS-1:0] dv);
        logic [4*DIGITS-1:0] c;
        c = dv;
        for (int k = 0; k < DIGITS; k++)
            if (dv[4*k +: 4] > 4'd9)
                c[4*k +: 4] = 4'd0;
        return c;
    endfunction

    // Returns {wrap, next}; carry/borrow ripples fully within one step so
    // a direction change can never split it.
    function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] cur, input logic up);
        logic [4*DIGITS-1:0] nxt;
        logic                carry;
        logic [3:0]          dig;
        nxt   = cur;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dig = cur[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (dig >= 4'd9) begin
                        nxt[4*k +: 4] = 4'd0;
                    end else begin
                        nxt[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        nxt[4*k +: 4] = 4'd9;
                    end else begin
                        nxt[4*k +: 4] = (dig > 4'd9) ? 4'd9 : dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return {carry, nxt};
    endfunction

    assign tick        = En && (presc == PW'(PRESCALE - 1));
    assign step_result = bcd_step(Q, Up);

    // Prescaler, count and wrap pulse; load takes priority over tick.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
            Q     <= '0;
            Wrap  <= 1'b0;
        end else if (Load) begin
            presc <= '0;
            Q     <= load_clean(D);
            Wrap  <= 1'b0;
        end else if (tick) begin
            presc <= '0;
            Q     <= step_result[4*DIGITS-1:0];
            Wrap  <= step_result[4*DIGITS];
        end else begin
            if (En)
                presc <= presc + PW'(1);
            Wrap <= 1'b0;
        end
    end

    // Segment register follows Q with one clock of latency.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            HEX <= encode_all('0);
        else
            HEX <= encode_all(Q);
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display: DIGITS=2, PRESCALE=4. A behavioural model pushes
// the expected Q/HEX/Wrap per clock into a queue; each edge pops and compares.
module tb_bcd_counter_display;

    logic        Clock;
    logic        Resetn;
    logic        En;
    logic        Up;
    logic        Load;
    logic [7:0]  D;
    logic [7:0]  Q;
    logic [13:0] HEX;
    logic        Wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  q;
        logic [13:0] hex;
        logic        w;
    } exp_t;

    exp_t sb[$];

    int          mq;
    int          mp;
    logic        mw;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [13:0] HEX_ZERO = {7'h7F, 7'h40};
`else
    localparam logic [13:0] HEX_ZERO = {7'h40, 7'h40};
`endif

    bcd_counter_display #(.DIGITS(2), .PRESCALE(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .En     (En),
        .Up     (Up),
        .Load   (Load),
        .D      (D),
        .Q      (Q),
        .HEX    (HEX),
        .Wrap   (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [13:0] mhex(input int v);
        logic [6:0] hi;
        hi = seg_tab[v / 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (v / 10 == 0) hi = 7'h7F;
`endif
        return {hi, seg_tab[v % 10]};
    endfunction

    function automatic int clean(input logic [7:0] dv);
        int hi;
        int lo;
        hi = (dv[7:4] > 4'd9) ? 0 : int'(dv[7:4]);
        lo = (dv[3:0] > 4'd9) ? 0 : int'(dv[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mq = 0;
        mp = 0;
        mw = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic en, input logic up, input logic ld, input logic [7:0] d);
        int   oq;
        exp_t e;
        En   = en;
        Up   = up;
        Load = ld;
        D    = d;
        oq   = mq;
        if (ld) begin
            mq = clean(d);
            mp = 0;
            mw = 1'b0;
        end else if (en && mp == 3) begin
            mp = 0;
            if (up) begin
                mw = (oq == 99);
                mq = (oq + 1) % 100;
            end else begin
                mw = (oq == 0);
                mq = (oq + 99) % 100;
            end
        end else begin
            if (en) mp++;
            mw = 1'b0;
        end
        e.q   = to_bcd(mq);
        e.hex = mhex(oq);
        e.w   = mw;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_q",    {24'd0, Q},    {24'd0, e.q});
            chk("sb_hex",  {18'd0, HEX},  {18'd0, e.hex});
            chk("sb_wrap", {31'd0, Wrap}, {31'd0, e.w});
        end
    endtask

    task automatic steps(input int n, input logic en, input logic up);
        for (int i = 0; i < n; i++) step(en, up, 1'b0, 8'h00);
    endtask

    initial begin
        Resetn = 1'b0;
        En     = 1'b0;
        Up     = 1'b1;
        Load   = 1'b0;
        D      = 8'h00;
        model_reset();

        #12;
        chk("rst_q",    {24'd0, Q},    32'h00);
        chk("rst_wrap", {31'd0, Wrap}, 32'h0);
        chk("rst_hex",  {18'd0, HEX},  {18'd0, HEX_ZERO});
        #8;
        Resetn = 1'b1;

        // Count up 00..10 over 40 clocks
        steps(40, 1'b1, 1'b1);
        chk("up40_q", {24'd0, Q}, 32'h10);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("up40_hex", {18'd0, HEX}, {18'd0, 7'h79, 7'h40});

        // Roll over 98 -> 99 -> 00
        step(1'b0, 1'b1, 1'b1, 8'h98);
        chk("ld98_q", {24'd0, Q}, 32'h98);
        steps(4, 1'b1, 1'b1);
        chk("inc99_q", {24'd0, Q}, 32'h99);
        steps(4, 1'b1, 1'b1);
        chk("wrap_up_q",    {24'd0, Q},    32'h00);
        chk("wrap_up_wrap", {31'd0, Wrap}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap_up_clear", {31'd0, Wrap}, 32'h0);
        chk("wrap_up_hex",   {18'd0, HEX},  {18'd0, HEX_ZERO});

        // Count down 00 -> 99 -> 98
        step(1'b0, 1'b0, 1'b1, 8'h00);
        steps(4, 1'b1, 1'b0);
        chk("wrap_dn_q",    {24'd0, Q},    32'h99);
        chk("wrap_dn_wrap", {31'd0, Wrap}, 32'h1);
        steps(4, 1'b1, 1'b0);
        chk("dec98_q",    {24'd0, Q},    32'h98);
        chk("dec98_wrap", {31'd0, Wrap}, 32'h0);

        // Illegal digits load as 0; load beats a coincident tick
        step(1'b0, 1'b1, 1'b1, 8'hAF);
        chk("ldAF_q", {24'd0, Q}, 32'h00);
        steps(3, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h37);
        chk("ld_tick_q",    {24'd0, Q},    32'h37);
        chk("ld_tick_wrap", {31'd0, Wrap}, 32'h0);
        steps(3, 1'b1, 1'b1);
        chk("ld_presc_q", {24'd0, Q}, 32'h37);
        steps(1, 1'b1, 1'b1);
        chk("ld_presc_next", {24'd0, Q}, 32'h38);

        // Freeze mid-count
        steps(2, 1'b1, 1'b1);
        steps(20, 1'b0, 1'b1);
        chk("freeze_q", {24'd0, Q}, 32'h38);
        steps(2, 1'b1, 1'b1);
        chk("freeze_resume", {24'd0, Q}, 32'h39);

        // Short reset pulse while a wrap pulse is showing
        step(1'b0, 1'b1, 1'b1, 8'h99);
        steps(4, 1'b1, 1'b1);
        chk("pre_rst_wrap", {31'd0, Wrap}, 32'h1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_q",    {24'd0, Q},    32'h00);
        chk("async_wrap", {31'd0, Wrap}, 32'h0);
        chk("async_hex",  {18'd0, HEX},  {18'd0, HEX_ZERO});
        model_reset();
        #2;
        Resetn = 1'b1;
        steps(3, 1'b1, 1'b1);
        chk("post_rst_hold", {24'd0, Q}, 32'h00);
        steps(1, 1'b1, 1'b1);
        chk("post_rst_tick", {24'd0, Q}, 32'h01);

        // Random enables, directions and loads
        for (int i = 0; i < 120; i++) begin
            logic [7:0] rd;
            rd = 8'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 15) == 0), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
